// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial WIDTH-bit subtractor, diff = a - b, LSB first.
// One full-subtractor cell is reused across WIDTH cycles with a registered
// borrow between bits. A start/done handshake wraps the operation.
// Optional feature macro: SUB_OVF_EN adds a signed-overflow output `ovf`.
//
// Handshake: `start` is sampled only in IDLE; the edge that samples it is the
// accept edge. `busy` is high from the accept edge until `done` rises.
// `done` is a one-cycle pulse marking `diff`/`borrow` (and `ovf`) valid.
// `start` seen while busy or done is dropped, not queued.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
`ifdef SUB_OVF_EN
  output logic             ovf,
`endif
  output logic [1:0]       dbg_state
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [WIDTH-1:0]  r_a;
  logic [WIDTH-1:0]  r_b;
  logic [WIDTH-1:0]  r_res;
  logic              r_bin;
  logic [CNT_W-1:0]  r_cnt;
  logic [WIDTH-1:0]  r_diff;
  logic              r_borrow;
  logic              w_last;
  logic              w_ai;
  logic              w_bi;
  logic              w_d;
  logic              w_bout;
`ifdef SUB_OVF_EN
  logic              r_a_msb;
  logic              r_b_msb;
  logic              r_ovf;
`endif

  // One-bit full-subtractor cell fed by the operand LSBs and the borrow flop
  assign w_ai   = r_a[0];
  assign w_bi   = r_b[0];
  assign w_d    = w_ai ^ w_bi ^ r_bin;
  assign w_bout = (~w_ai & w_bi) | (~(w_ai ^ w_bi) & r_bin);
  assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

  // Outputs come straight from state/result registers
  assign busy      = (r_state == S_SHIFT);
  assign done      = (r_state == S_DONE);
  assign diff      = r_diff;
  assign borrow    = r_borrow;
  assign dbg_state = r_state;
`ifdef SUB_OVF_EN
  assign ovf       = r_ovf;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic: accept, run WIDTH bit cycles, one done cycle
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (start)  w_next = S_SHIFT;
      S_SHIFT: if (w_last) w_next = S_DONE;
      S_DONE:              w_next = S_IDLE;
      default:             w_next = S_IDLE;
    endcase
  end

  // Datapath: capture on accept, shift one bit per SHIFT cycle, publish on last bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_res    <= '0;
      r_bin    <= 1'b0;
      r_cnt    <= '0;
      r_diff   <= '0;
      r_borrow <= 1'b0;
`ifdef SUB_OVF_EN
      r_a_msb  <= 1'b0;
      r_b_msb  <= 1'b0;
      r_ovf    <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_res   <= '0;
            r_bin   <= 1'b0;
            r_cnt   <= '0;
`ifdef SUB_OVF_EN
            r_a_msb <= a[WIDTH-1];
            r_b_msb <= b[WIDTH-1];
`endif
          end
        end
        S_SHIFT: begin
          r_res <= {w_d, r_res[WIDTH-1:1]};
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_bin <= w_bout;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            // The bit computed this cycle is the result MSB
            r_diff   <= {w_d, r_res[WIDTH-1:1]};
            r_borrow <= w_bout;
`ifdef SUB_OVF_EN
            r_ovf    <= (r_a_msb != r_b_msb) && (w_d != r_a_msb);
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule
